scr1_tb_axi_arbiter: RTL

//  N_M-to-1 AXI4 arbiter for the testbench memory: shares one slave AXI port (the TB AXI memory) between
//  N_M core-side masters (e.g. IMEM + DMEM bridges). Independent read and write arbiters, round-robin,
//  one outstanding transaction per direction; a grant is held from address accept to final response.

---
 rtl/scr1_tb_axi_arbiter.sv | 263 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/scr1_tb_axi_arbiter.sv
// N_M-to-1 AXI4 arbiter sharing one slave port between several masters.
// Independent round-robin read and write arbiters, one outstanding transaction per direction.
module scr1_tb_axi_arbiter #(
    parameter int N_M    = 2,
    parameter int W_ID   = 4,
    parameter int W_ADR  = 32,
    parameter int W_DATA = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    // master write address
    input  logic [N_M-1:0]               m_awvalid,
    input  logic [N_M*W_ID-1:0]          m_awid,
    input  logic [N_M*W_ADR-1:0]         m_awaddr,
    input  logic [N_M*3-1:0]             m_awsize,
    input  logic [N_M*8-1:0]             m_awlen,
    output logic [N_M-1:0]               m_awready,
    // master write data
    input  logic [N_M-1:0]               m_wvalid,
    input  logic [N_M*W_DATA-1:0]        m_wdata,
    input  logic [N_M*(W_DATA/8)-1:0]    m_wstrb,
    input  logic [N_M-1:0]               m_wlast,
    output logic [N_M-1:0]               m_wready,
    // master write response
    output logic [N_M-1:0]               m_bvalid,
    input  logic [N_M-1:0]               m_bready,
    output logic [W_ID-1:0]              m_bid,
    output logic [1:0]                   m_bresp,
    // master read address
    input  logic [N_M-1:0]               m_arvalid,
    input  logic [N_M*W_ID-1:0]          m_arid,
    input  logic [N_M*W_ADR-1:0]         m_araddr,
    input  logic [N_M*2-1:0]             m_arburst,
    input  logic [N_M*3-1:0]             m_arsize,
    input  logic [N_M*8-1:0]             m_arlen,
    output logic [N_M-1:0]               m_arready,
    // master read data
    output logic [N_M-1:0]               m_rvalid,
    input  logic [N_M-1:0]               m_rready,
    output logic [W_ID-1:0]              m_rid,
    output logic [W_DATA-1:0]            m_rdata,
    output logic                         m_rlast,
    output logic [1:0]                   m_rresp,
    // slave write address
    output logic                         s_awvalid,
    input  logic                         s_awready,
    output logic [W_ID-1:0]              s_awid,
    output logic [W_ADR-1:0]             s_awaddr,
    output logic [2:0]                   s_awsize,
    output logic [7:0]                   s_awlen,
    // slave write data
    output logic                         s_wvalid,
    input  logic                         s_wready,
    output logic [W_DATA-1:0]            s_wdata,
    output logic [W_DATA/8-1:0]          s_wstrb,
    output logic                         s_wlast,
    // slave write response
    input  logic                         s_bvalid,
    output logic                         s_bready,
    input  logic [W_ID-1:0]              s_bid,
    input  logic [1:0]                   s_bresp,
    // slave read address
    output logic                         s_arvalid,
    input  logic                         s_arready,
    output logic [W_ID-1:0]              s_arid,
    output logic [W_ADR-1:0]             s_araddr,
    output logic [1:0]                   s_arburst,
    output logic [2:0]                   s_arsize,
    output logic [7:0]                   s_arlen,
    // slave read data
    input  logic                         s_rvalid,
    output logic                         s_rready,
    input  logic [W_ID-1:0]              s_rid,
    input  logic [W_DATA-1:0]            s_rdata,
    input  logic                         s_rlast,
    input  logic [1:0]                   s_rresp
);

    localparam int W_IDX  = $clog2(N_M);
    localparam int W_STRB = W_DATA / 8;

    typedef enum logic [1:0] {R_IDLE = 2'd0, R_ADDR = 2'd1, R_DATA = 2'd2} rd_state_t;
    typedef enum logic [1:0] {W_IDLE = 2'd0, W_XFER = 2'd1, W_RESP = 2'd2} wr_state_t;

    // Returns {found, index} of the first request at or after ptr, wrapping.
    function automatic logic [W_IDX:0] rr_pick(input logic [N_M-1:0] req, input logic [W_IDX-1:0] ptr);
        logic             found;
        logic [W_IDX-1:0] sel;
        int               idx;
        found = 1'b0;
        sel   = ptr;
        for (int i = 0; i < N_M; i++) begin
            idx = int'(ptr) + i;
            idx = (idx >= N_M) ? idx - N_M : idx;
            if (!found && req[W_IDX'(idx)]) begin
                found = 1'b1;
                sel   = W_IDX'(idx);
            end
        end
        return {found, sel};
    endfunction

    function automatic logic [W_IDX-1:0] ptr_inc(input logic [W_IDX-1:0] g);
        return (int'(g) == N_M - 1) ? {W_IDX{1'b0}} : g + W_IDX'(1);
    endfunction

    rd_state_t        rd_state_q, rd_state_d;
    logic [W_IDX-1:0] rd_g_q, rd_g_d, rd_ptr_q, rd_ptr_d;
    logic [W_IDX:0]   rd_pick_s;

    wr_state_t        wr_state_q, wr_state_d;
    logic [W_IDX-1:0] wr_g_q, wr_g_d, wr_ptr_q, wr_ptr_d;
    logic [W_IDX:0]   wr_pick_s;
    logic             aw_done_q, aw_done_d, w_done_q, w_done_d;

    // Read arbiter state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state_q <= R_IDLE;
            rd_g_q     <= {W_IDX{1'b0}};
            rd_ptr_q   <= {W_IDX{1'b0}};
        end else begin
            rd_state_q <= rd_state_d;
            rd_g_q     <= rd_g_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // Read arbiter next state and per-master valid/ready gating
    always_comb begin
        rd_state_d = rd_state_q;
        rd_g_d     = rd_g_q;
        rd_ptr_d   = rd_ptr_q;
        rd_pick_s  = rr_pick(m_arvalid, rd_ptr_q);
        s_arvalid  = 1'b0;
        s_rready   = 1'b0;
        m_arready  = {N_M{1'b0}};
        m_rvalid   = {N_M{1'b0}};
        case (rd_state_q)
            R_IDLE: begin
                if (rd_pick_s[W_IDX]) begin
                    rd_g_d     = rd_pick_s[W_IDX-1:0];
                    rd_state_d = R_ADDR;
                end else begin
                    rd_state_d = R_IDLE;
                end
            end
            R_ADDR: begin
                s_arvalid         = m_arvalid[rd_g_q];
                m_arready[rd_g_q] = s_arready;
                if (s_arvalid && s_arready) begin
                    rd_state_d = R_DATA;
                end else begin
                    rd_state_d = R_ADDR;
                end
            end
            R_DATA: begin
                m_rvalid[rd_g_q] = s_rvalid;
                s_rready         = m_rready[rd_g_q];
                if (s_rvalid && s_rready && s_rlast) begin
                    rd_state_d = R_IDLE;
                    rd_ptr_d   = ptr_inc(rd_g_q);
                end else begin
                    rd_state_d = R_DATA;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    // Write arbiter state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state_q <= W_IDLE;
            wr_g_q     <= {W_IDX{1'b0}};
            wr_ptr_q   <= {W_IDX{1'b0}};
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            wr_g_q     <= wr_g_d;
            wr_ptr_q   <= wr_ptr_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
        end
    end

    // Write arbiter next state; AW and W each close independently, then wait for B
    always_comb begin
        wr_state_d = wr_state_q;
        wr_g_d     = wr_g_q;
        wr_ptr_d   = wr_ptr_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        wr_pick_s  = rr_pick(m_awvalid, wr_ptr_q);
        s_awvalid  = 1'b0;
        s_wvalid   = 1'b0;
        s_bready   = 1'b0;
        m_awready  = {N_M{1'b0}};
        m_wready   = {N_M{1'b0}};
        m_bvalid   = {N_M{1'b0}};
        case (wr_state_q)
            W_IDLE: begin
                if (wr_pick_s[W_IDX]) begin
                    wr_g_d     = wr_pick_s[W_IDX-1:0];
                    wr_state_d = W_XFER;
                end else begin
                    wr_state_d = W_IDLE;
                end
            end
            W_XFER: begin
                s_awvalid         = !aw_done_q && m_awvalid[wr_g_q];
                m_awready[wr_g_q] = !aw_done_q && s_awready;
                s_wvalid          = !w_done_q && m_wvalid[wr_g_q];
                m_wready[wr_g_q]  = !w_done_q && s_wready;
                aw_done_d         = aw_done_q || (s_awvalid && s_awready);
                w_done_d          = w_done_q || (s_wvalid && s_wready && s_wlast);
                if (aw_done_d && w_done_d) begin
                    wr_state_d = W_RESP;
                    aw_done_d  = 1'b0;
                    w_done_d   = 1'b0;
                end else begin
                    wr_state_d = W_XFER;
                end
            end
            W_RESP: begin
                m_bvalid[wr_g_q] = s_bvalid;
                s_bready         = m_bready[wr_g_q];
                if (s_bvalid && s_bready) begin
                    wr_state_d = W_IDLE;
                    wr_ptr_d   = ptr_inc(wr_g_q);
                end else begin
                    wr_state_d = W_RESP;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    // Slave-side payloads follow the registered grants; only valids are gated
    always_comb begin
        s_arid    = m_arid[int'(rd_g_q)*W_ID +: W_ID];
        s_araddr  = m_araddr[int'(rd_g_q)*W_ADR +: W_ADR];
        s_arburst = m_arburst[int'(rd_g_q)*2 +: 2];
        s_arsize  = m_arsize[int'(rd_g_q)*3 +: 3];
        s_arlen   = m_arlen[int'(rd_g_q)*8 +: 8];
        s_awid    = m_awid[int'(wr_g_q)*W_ID +: W_ID];
        s_awaddr  = m_awaddr[int'(wr_g_q)*W_ADR +: W_ADR];
        s_awsize  = m_awsize[int'(wr_g_q)*3 +: 3];
        s_awlen   = m_awlen[int'(wr_g_q)*8 +: 8];
        s_wdata   = m_wdata[int'(wr_g_q)*W_DATA +: W_DATA];
        s_wstrb   = m_wstrb[int'(wr_g_q)*W_STRB +: W_STRB];
        s_wlast   = m_wlast[wr_g_q];
    end

    assign m_rid   = s_rid;
    assign m_rdata = s_rdata;
    assign m_rlast = s_rlast;
    assign m_rresp = s_rresp;
    assign m_bid   = s_bid;
    assign m_bresp = s_bresp;

endmodule
